// File: rtl/llr_sched_pkg.sv
// Shared types and constants for the per-user LLR send scheduler.
// State encoding is one-hot so each state bit can be probed directly.
package llr_sched_pkg;

  localparam int RE_W    = 16;
  localparam int RATE_W  = 16;
  localparam int ENTRY_W = RE_W + RATE_W;

  typedef enum logic [7:0] {
    ST_IDLE = 8'h01,
    ST_LOAD = 8'h02,
    ST_RST  = 8'h04,
    ST_RUN  = 8'h08,
    ST_NEXT = 8'h10,
    ST_DONE = 8'h20
  } sched_state_e;

  // Table entry: re_amounts in [15:0], IQ/noise rate in [31:16].
  typedef struct packed {
    logic [RATE_W-1:0] rate;
    logic [RE_W-1:0]   re_amounts;
  } cfg_entry_t;

  // Strobes the sender emits for one user: 2*ceil(re/4), in 17 bits.
  function automatic logic [16:0] strobe_target(input logic [RE_W-1:0] re);
    logic [16:0] s;
    s = {1'b0, re} + 17'd3;
    return {1'b0, s[16:2], 1'b0};
  endfunction

endpackage

// File: rtl/llr_user_cfg_table.sv
// Per-user configuration register file: one synchronous write port,
// one combinational read port. A same-cycle write/read returns old data.
module llr_user_cfg_table
  import llr_sched_pkg::*;
#(
  parameter int MAX_USERS  = 8,
  parameter int USER_IDX_W = 3
) (
  input  logic                  i_core_clk,
  input  logic                  i_rx_rstn,
  input  logic                  i_wr_en,
  input  logic [USER_IDX_W-1:0] i_wr_addr,
  input  logic [ENTRY_W-1:0]    i_wr_data,
  input  logic [USER_IDX_W-1:0] i_rd_addr,
  output logic [ENTRY_W-1:0]    o_rd_data
);

  logic [ENTRY_W-1:0] mem [MAX_USERS];

  // Table storage; out-of-range writes are dropped.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      for (int i = 0; i < MAX_USERS; i++) mem[i] <= '0;
    end else if (i_wr_en && (32'(i_wr_addr) < MAX_USERS)) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/llr_user_send_scheduler.sv
// Per-user sequencer for the slow-PHY-to-LLR sender. Walks users 0..N-1,
// presents each user's config, holds the sender FSM in reset, then counts
// sender data strobes until the user is finished or the sender stalls.
// Optional macro LLR_SCHED_PERF_EN adds per-user cycle statistics.
//
// Sender interface: o_rx_fsm_rstn high means the sender may run; every
// cycle with i_sender_strobe=1 while running is one completed data beat.
// There is no backpressure; the scheduler only observes the strobes.
module llr_user_send_scheduler
  import llr_sched_pkg::*;
#(
  parameter int          MAX_USERS      = 8,
  parameter int          USER_IDX_W     = 3,
  parameter int          RST_CYCLES     = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                  i_core_clk,
  input  logic                  i_rx_rstn,
  input  logic                  i_cfg_wr_en,
  input  logic [USER_IDX_W-1:0] i_cfg_wr_addr,
  input  logic [15:0]           i_cfg_wr_re_amounts,
  input  logic [15:0]           i_cfg_wr_iq_noise_rate,
  input  logic                  i_sched_start,
  input  logic [USER_IDX_W:0]   i_num_users,
  input  logic                  i_sender_strobe,
  output logic                  o_rx_fsm_rstn,
  output logic [15:0]           o_cur_user_re_amounts,
  output logic [15:0]           o_user_iq_noise_rate,
  output logic [USER_IDX_W-1:0] o_cur_user_idx,
  output logic                  o_busy,
  output logic                  o_user_done,
  output logic                  o_all_done,
  output logic                  o_timeout_err,
  output sched_state_e          o_dbg_state
`ifdef LLR_SCHED_PERF_EN
  ,
  output logic [15:0]           o_user_cycles,
  output logic [15:0]           o_max_user_cycles
`endif
);

  localparam logic [USER_IDX_W:0] MAX_U      = (USER_IDX_W+1)'(MAX_USERS);
  localparam logic [15:0]         RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [16:0]         STALL_LAST = {1'b0, TIMEOUT_CYCLES} - 17'd1;
  localparam logic [16:0]         CNT_MAX    = '1;

  sched_state_e          state, nxt;
  logic [USER_IDX_W-1:0] idx;
  logic [USER_IDX_W:0]   num_users_q, num_clamped, idx_plus1;
  logic [15:0]           rst_cnt;
  logic [16:0]           target_n, strobe_cnt, stall_cnt, strobe_inc, stall_inc;
  logic [ENTRY_W-1:0]    rd_data;
  cfg_entry_t            rd_entry;
  logic                  skip_user;

  llr_user_cfg_table #(
    .MAX_USERS  (MAX_USERS),
    .USER_IDX_W (USER_IDX_W)
  ) u_cfg_table (
    .i_core_clk (i_core_clk),
    .i_rx_rstn  (i_rx_rstn),
    .i_wr_en    (i_cfg_wr_en),
    .i_wr_addr  (i_cfg_wr_addr),
    .i_wr_data  ({i_cfg_wr_iq_noise_rate, i_cfg_wr_re_amounts}),
    .i_rd_addr  (idx),
    .o_rd_data  (rd_data)
  );

  assign rd_entry       = cfg_entry_t'(rd_data);
  assign skip_user      = (rd_entry.re_amounts == '0) || (rd_entry.rate == '0);
  assign num_clamped    = (i_num_users > MAX_U) ? MAX_U : i_num_users;
  assign idx_plus1      = {1'b0, idx} + (USER_IDX_W+1)'(1);
  assign strobe_inc     = (i_sender_strobe && strobe_cnt != CNT_MAX) ? strobe_cnt + 17'd1 : strobe_cnt;
  assign stall_inc      = (stall_cnt != CNT_MAX) ? stall_cnt + 17'd1 : stall_cnt;
  assign o_cur_user_idx = idx;
  assign o_dbg_state    = state;

  // Next-state decode; completion is checked before the stall timeout.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (i_sched_start) nxt = (num_clamped == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD: nxt = skip_user ? ST_NEXT : ST_RST;
      ST_RST:  if (rst_cnt == RST_LAST) nxt = ST_RUN;
      ST_RUN: begin
        if (strobe_inc == target_n) nxt = ST_NEXT;
        else if (!i_sender_strobe && stall_cnt == STALL_LAST) nxt = ST_DONE;
      end
      ST_NEXT: nxt = (idx_plus1 == num_users_q) ? ST_DONE : ST_LOAD;
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Scheduler FSM with all outputs registered from the next state.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state                 <= ST_IDLE;
      idx                   <= '0;
      num_users_q           <= '0;
      rst_cnt               <= '0;
      target_n              <= '0;
      strobe_cnt            <= '0;
      stall_cnt             <= '0;
      o_rx_fsm_rstn         <= 1'b0;
      o_cur_user_re_amounts <= '0;
      o_user_iq_noise_rate  <= '0;
      o_busy                <= 1'b0;
      o_user_done           <= 1'b0;
      o_all_done            <= 1'b0;
      o_timeout_err         <= 1'b0;
    end else begin
      state         <= nxt;
      o_rx_fsm_rstn <= (nxt == ST_RUN);
      o_busy        <= (nxt != ST_IDLE);
      o_user_done   <= (nxt == ST_NEXT);
      o_all_done    <= (nxt == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (i_sched_start) begin
            idx           <= '0;
            num_users_q   <= num_clamped;
            o_timeout_err <= 1'b0;
          end
        end
        ST_LOAD: begin
          o_cur_user_re_amounts <= rd_entry.re_amounts;
          o_user_iq_noise_rate  <= rd_entry.rate;
          target_n              <= strobe_target(rd_entry.re_amounts);
          rst_cnt               <= '0;
          strobe_cnt            <= '0;
          stall_cnt             <= '0;
        end
        ST_RST:  rst_cnt <= rst_cnt + 16'd1;
        ST_RUN: begin
          strobe_cnt <= strobe_inc;
          stall_cnt  <= i_sender_strobe ? 17'd0 : stall_inc;
          if (nxt == ST_DONE) o_timeout_err <= 1'b1;
        end
        ST_NEXT: idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef LLR_SCHED_PERF_EN
  logic [15:0] cyc_cnt, cyc_inc;
  assign cyc_inc = (cyc_cnt != 16'hFFFF) ? cyc_cnt + 16'd1 : cyc_cnt;

  // Per-user cycle count from RST entry to NEXT, plus running maximum.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      cyc_cnt           <= '0;
      o_user_cycles     <= '0;
      o_max_user_cycles <= '0;
    end else begin
      if (state == ST_IDLE && i_sched_start) o_max_user_cycles <= '0;
      if (state == ST_LOAD) cyc_cnt <= '0;
      else if (state == ST_RST || state == ST_RUN) cyc_cnt <= cyc_inc;
      if (nxt == ST_NEXT) begin
        if (state == ST_LOAD) begin
          o_user_cycles <= '0;
        end else begin
          o_user_cycles <= cyc_inc;
          if (cyc_inc > o_max_user_cycles) o_max_user_cycles <= cyc_inc;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_llr_user_send_scheduler.sv
// Self-checking bench for llr_user_send_scheduler (stall timeout shortened to 16).
module tb_llr_user_send_scheduler;

  localparam int RST_CYC = 2;
  localparam int W       = 53;

  logic        clk, rstn;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_re, wr_rate;
  logic        start;
  logic [3:0]  num_users;
  logic        strobe;
  logic        fsm_rstn, busy, user_done, all_done, terr;
  logic [15:0] cur_re, cur_rate;
  logic [2:0]  cur_idx;
  logic [7:0]  dbg_state;
`ifdef LLR_SCHED_PERF_EN
  logic [15:0] user_cycles, max_user_cycles;
`endif

  llr_user_send_scheduler #(
    .MAX_USERS(8), .USER_IDX_W(3), .RST_CYCLES(RST_CYC), .TIMEOUT_CYCLES(16'd16)
  ) dut (
    .i_core_clk(clk), .i_rx_rstn(rstn),
    .i_cfg_wr_en(wr_en), .i_cfg_wr_addr(wr_addr),
    .i_cfg_wr_re_amounts(wr_re), .i_cfg_wr_iq_noise_rate(wr_rate),
    .i_sched_start(start), .i_num_users(num_users), .i_sender_strobe(strobe),
    .o_rx_fsm_rstn(fsm_rstn), .o_cur_user_re_amounts(cur_re),
    .o_user_iq_noise_rate(cur_rate), .o_cur_user_idx(cur_idx),
    .o_busy(busy), .o_user_done(user_done), .o_all_done(all_done),
    .o_timeout_err(terr), .o_dbg_state(dbg_state)
`ifdef LLR_SCHED_PERF_EN
    , .o_user_cycles(user_cycles), .o_max_user_cycles(max_user_cycles)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, run_cyc = 0, strb_cnt = 0, last_strb_cyc = 0;
  int rise_cyc = -100, terr_cyc = -100, ud_cyc = -100, ad_cyc = -100;
  int user_done_cnt = 0, all_done_cnt = 0, rise_cnt = 0;
  bit prev_rstn = 0, prev_terr = 0, all_done_flag = 0, strobe_en = 1;

  typedef struct {
    logic [15:0] re;
    logic [15:0] rate;
    logic [16:0] exp_n;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // record: {kind, idx, re, rate, n}; kind 1 = all_done
  function automatic logic [W-1:0] urec(input logic [2:0] i, input logic [15:0] re,
                                        input logic [15:0] rate, input logic [16:0] n);
    return {1'b0, i, re, rate, n};
  endfunction
  function automatic logic [W-1:0] arec();
    logic [W-1:0] r;
    r = '0;
    r[W-1] = 1'b1;
    return r;
  endfunction
  function automatic logic [16:0] model_n(input int re);
    return 17'(2 * ((re + 3) / 4));
  endfunction

  // monitor, sampled on the falling edge
  task automatic monitor();
    logic [W-1:0] e;
    if (fsm_rstn) begin
      run_cyc++;
      if (strobe) begin strb_cnt++; last_strb_cyc = cyc; end
    end
    if (fsm_rstn && !prev_rstn) begin rise_cyc = cyc; rise_cnt++; end
    if (terr && !prev_terr) terr_cyc = cyc;
    prev_rstn = fsm_rstn;
    prev_terr = terr;
    if (user_done) begin
      user_done_cnt++;
      ud_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_user_done: idx %0d, expected no pulse", cur_idx);
      end else begin
        e = exp_q.pop_front();
        chk("rec_kind_user", 0, e[52]);
        chk("user_idx", cur_idx, e[51:49]);
        chk("user_re", cur_re, e[48:33]);
        chk("user_rate", cur_rate, e[32:17]);
        chk("user_strobes", strb_cnt, e[16:0]);
        if (e[16:0] == 0) chk("skip_no_run", run_cyc, 0);
        else chk("done_latency", cyc - last_strb_cyc, 1);
`ifdef LLR_SCHED_PERF_EN
        chk("perf_user_cycles", user_cycles, (e[16:0] == 0) ? 0 : RST_CYC + run_cyc);
`endif
      end
      strb_cnt = 0; run_cyc = 0;
    end
    if (all_done) begin
      all_done_cnt++;
      ad_cyc = cyc;
      all_done_flag = 1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_all_done: expected no pulse");
      end else begin
        e = exp_q.pop_front();
        chk("rec_kind_all", 1, e[52]);
      end
      strb_cnt = 0; run_cyc = 0;
    end
  endtask

  // one cycle: monitor at negedge, drive inputs 1 time unit after posedge
  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
    strobe = strobe_en && fsm_rstn && ($urandom_range(0, 3) != 0);
  endtask

  task automatic write_entry(input int a, input int re, input int rate);
    wr_en = 1; wr_addr = 3'(a); wr_re = 16'(re); wr_rate = 16'(rate);
    tick();
    wr_en = 0;
  endtask

  task automatic start_sched(input int n);
    all_done_flag = 0;
    num_users = 4'(n); start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_all_done(input string name, input int budget);
    for (int i = 0; i < budget && !all_done_flag; i++) tick();
    if (!all_done_flag) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no all_done within %0d cycles, expected pulse", name, budget);
    end
  endtask

  task automatic wait_run(input string name, input int budget);
    for (int i = 0; i < budget && !fsm_rstn; i++) tick();
    chk({name, "_run_reached"}, fsm_rstn, 1);
  endtask

  int st, ud0, ad0, rc0;

  initial begin
    vecs[0] = '{16'd1,  16'd1, 17'd2};
    vecs[1] = '{16'd3,  16'd5, 17'd2};
    vecs[2] = '{16'd4,  16'd7, 17'd2};
    vecs[3] = '{16'd5,  16'd1, 17'd4};
    vecs[4] = '{16'd13, 16'd2, 17'd8};
    vecs[5] = '{16'd16, 16'd9, 17'd8};
    vecs[6] = '{16'd17, 16'd1, 17'd10};
    vecs[7] = '{16'd0,  16'd4, 17'd0};
    vecs[8] = '{16'd6,  16'd0, 17'd0};

    rstn = 0; wr_en = 0; wr_addr = 0; wr_re = 0; wr_rate = 0;
    start = 0; num_users = 0; strobe = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fsm_rstn", fsm_rstn, 0);
    chk("reset_busy", busy, 0);
    chk("reset_all_done", all_done, 0);
    chk("reset_state", dbg_state, 8'h01);
    rstn = 1;
    tick();

    // scenario 1: single user, re=12 -> 6 strobes
    write_entry(0, 12, 2);
    exp_q.push_back(urec(0, 12, 2, 6));
    exp_q.push_back(arec());
    ud0 = user_done_cnt;
    start_sched(1);
    st = cyc;
    wait_all_done("s1", 200);
    chk("s1_rstn_rise", rise_cyc - st, 2 + RST_CYC);
    chk("s1_all_after_user", ad_cyc - ud_cyc, 1);
    chk("s1_user_done_cnt", user_done_cnt - ud0, 1);
    chk("s1_busy_idle", busy, 0);

    // table-driven N / skip vectors on entry 0
    for (int v = 0; v < 9; v++) begin
      write_entry(0, int'(vecs[v].re), int'(vecs[v].rate));
      exp_q.push_back(urec(0, vecs[v].re, vecs[v].rate, vecs[v].exp_n));
      exp_q.push_back(arec());
      ud0 = user_done_cnt;
      start_sched(1);
      wait_all_done("vec", 300);
      chk("vec_user_done_cnt", user_done_cnt - ud0, 1);
    end

    // scenario 2: re=8,0,5 -> 4, skipped, 4
    write_entry(0, 8, 1); write_entry(1, 0, 1); write_entry(2, 5, 1);
    exp_q.push_back(urec(0, 8, 1, 4));
    exp_q.push_back(urec(1, 0, 1, 0));
    exp_q.push_back(urec(2, 5, 1, 4));
    exp_q.push_back(arec());
    ud0 = user_done_cnt; ad0 = all_done_cnt; rc0 = rise_cnt;
    start_sched(3);
    wait_all_done("s2", 300);
    chk("s2_user_done_cnt", user_done_cnt - ud0, 3);
    chk("s2_all_done_cnt", all_done_cnt - ad0, 1);
    chk("s2_run_count", rise_cnt - rc0, 2);

    // scenario 3: stall timeout aborts the schedule
    strobe_en = 0;
    write_entry(0, 8, 1); write_entry(1, 8, 1);
    exp_q.push_back(arec());
    ud0 = user_done_cnt; rc0 = rise_cnt;
    start_sched(2);
    wait_all_done("s3", 100);
    chk("s3_timeout_delay", terr_cyc - rise_cyc, 16);
    chk("s3_all_done_with_err", ad_cyc, terr_cyc);
    chk("s3_no_user_done", user_done_cnt - ud0, 0);
    chk("s3_one_user_run", rise_cnt - rc0, 1);
    repeat (4) tick();
    chk("s3_err_sticky", terr, 1);
    strobe_en = 1;
    exp_q.push_back(urec(0, 8, 1, 4));
    exp_q.push_back(urec(1, 8, 1, 4));
    exp_q.push_back(arec());
    start_sched(2);
    chk("s3_err_cleared", terr, 0);
    wait_all_done("s3b", 300);

    // scenario 4: zero users, then 12 clamped to 8
    exp_q.push_back(arec());
    ud0 = user_done_cnt;
    start_sched(0);
    st = cyc;
    wait_all_done("s4a", 20);
    chk("s4_zero_latency", ad_cyc - st, 1);
    chk("s4_zero_no_user", user_done_cnt - ud0, 0);
    for (int i = 0; i < 8; i++) begin
      write_entry(i, i + 1, i + 1);
      exp_q.push_back(urec(3'(i), 16'(i + 1), 16'(i + 1), model_n(i + 1)));
    end
    exp_q.push_back(arec());
    ud0 = user_done_cnt;
    start_sched(12);
    wait_all_done("s4b", 1000);
    chk("s4_clamp_user_done", user_done_cnt - ud0, 8);

    // scenario 5: rewrite active entry mid-RUN, ignored start
    write_entry(0, 12, 2);
    exp_q.push_back(urec(0, 12, 2, 6));
    exp_q.push_back(arec());
    ad0 = all_done_cnt;
    start_sched(1);
    wait_run("s5", 20);
    write_entry(0, 40, 2);
    start = 1; tick(); start = 0;
    wait_all_done("s5", 200);
    repeat (4) tick();
    chk("s5_single_all_done", all_done_cnt - ad0, 1);
    chk("s5_idle_after", busy, 0);
    exp_q.push_back(urec(0, 40, 2, 20));
    exp_q.push_back(arec());
    start_sched(1);
    wait_all_done("s5b", 300);

    // scenario 6: asynchronous reset mid-RUN
    start_sched(1);
    wait_run("s6", 20);
    repeat (3) tick();
    rstn = 0;
    #1;
    chk("s6_fsm_rstn", fsm_rstn, 0);
    chk("s6_busy", busy, 0);
    chk("s6_cur_re", cur_re, 0);
    chk("s6_cur_rate", cur_rate, 0);
    chk("s6_cur_idx", cur_idx, 0);
    chk("s6_user_done", user_done, 0);
    chk("s6_state", dbg_state, 8'h01);
    exp_q.delete();
    strb_cnt = 0; run_cyc = 0;
    repeat (3) tick();
    rstn = 1;
    tick();
    // table cleared by reset: entry 0 is now skipped
    exp_q.push_back(urec(0, 0, 0, 0));
    exp_q.push_back(arec());
    start_sched(1);
    wait_all_done("s6b", 50);
    repeat (2) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
